read_word_gather: RTL and testbench
===================================

// Module: read_word_gather
// PURPOSE
//   Parametrised byte-gather engine: fetches 1..BYTES consecutive bytes from a byte-wide
//   strobed memory (UFM/config ROM, clocked by rd_clock) and packs them into one word.
//   Sits between the upgrade controller and the memory port. Adds run-time length, an
//   endianness select, configurable memory read latency and a busy/done handshake.
// PARAMETERS
//   DEPTH      256  memory depth in bytes; power of two; AW = clogb2(DEPTH)
//   BYTES      4    max bytes per word, 2..8; word width WW = 8*BYTES; NW = clogb2(BYTES)
//   RD_LAT     0    extra cycles from rd_clock-high cycle to rd_data sample, 0..3
// PORTS
//   clk        in   1    system clock, all logic on rising edge
//   reset_n    in   1    asynchronous, active-low reset
//   start      in   1    one-cycle request; samples addr, nbytes, big_endian
//   addr       in   AW   byte address of first byte
//   nbytes     in   NW   bytes to read; 0 encodes BYTES
//   big_endian in   1    0: first byte -> LSB; 1: first byte -> MS byte of nbytes field
//   word       out  WW   assembled word, unread bytes zero
//   busy       out  1    high while a read sequence is running
//   done       out  1    level; high from completion until next start
//   rd_data    in   8    memory read data
//   rd_addr    out  AW   memory byte address (registered)
//   rd_clock   out  1    memory read strobe (registered, one cycle high per byte)
// BEHAVIOUR
//   - Reset (reset_n=0, any time, mid-sequence included): word=0, busy=0, done=0,
//     rd_addr=0, rd_clock=0, FSM=IDLE; effective immediately, no partial word retained.
//   - FSM: IDLE -> SETUP -> STROBE -> WAIT(RD_LAT cycles, skipped if 0) -> SETUP | IDLE.
//   - start edge (any state): rd_addr<=addr, word<=0, done<=0, busy<=1, byte idx k<=0,
//     latch len=(nbytes==0?BYTES:nbytes) and big_endian, FSM<=SETUP, rd_clock<=0.
//     start while busy aborts the current sequence and restarts; no done for aborted one.
//   - SETUP: rd_clock=0, rd_addr stable (one setup cycle). Next: STROBE.
//   - STROBE: rd_clock=1 for exactly this cycle. Byte k sampled at the edge ending
//     cycle (STROBE + RD_LAT); at that edge rd_addr<=rd_addr+1, k<=k+1.
//   - Placement: LE byte k -> word[8k+:8]; BE byte k -> word[8*(len-1-k)+:8].
//   - Per byte 2+RD_LAT cycles; total len*(2+RD_LAT) cycles from start edge to final
//     capture edge. At final capture edge: busy<=0, done<=1, FSM<=IDLE, word final.
//     word and done change on the same edge; word holds until next start or reset.
//   - rd_addr wraps modulo DEPTH (0xFF+1 -> 0x00 for DEPTH=256); no error flag.
//     After completion rd_addr = addr+len (mod DEPTH) and holds.
//   - start held high several cycles: each cycle restarts; sequence runs after release.
//   - start ignored by nothing: start with reset_n=0 has no effect.
// TESTING
//   1. LE, RD_LAT=0, mem[i]=i, start addr=0x10 nbytes=0 -> word=0x13121110, done
//      rises 8 cycles after start edge, 4 rd_clock pulses, rd_addr ends 0x14.
//   2. BE, nbytes=3, addr=0x20, mem=AA,BB,CC -> word=0x00AABBCC; done after 6 cycles.
//   3. Wrap: DEPTH=256, addr=0xFE, nbytes=0 -> rd_addr sequence FE,FF,00,01; word
//      = {mem[01],mem[00],mem[FF],mem[FE]}; final rd_addr=0x02.
//   4. RD_LAT=2, nbytes=2, LE -> 4 cycles/byte, done at cycle 8, each byte sampled 2
//      cycles after its rd_clock cycle (bench ROM drives data only then).
//   5. start again at cycle 3 of a 4-byte read with addr=0x40 -> no done for first
//      sequence, word cleared, result = mem[0x43..0x40], done 8 cycles after 2nd start.
//   6. reset_n low mid-sequence (cycle 5) -> all outputs 0 asynchronously; after release
//      outputs stay idle until a new start.

Source files
------------

// File: rtl/read_word_gather.sv
// Gathers 1..BYTES consecutive bytes from a strobed byte memory and packs them into one word.
// Latency: len*(2+RD_LAT) cycles from the start edge to done; word and done update on the same edge.
// No backpressure: start restarts immediately, aborting any sequence in flight.
module read_word_gather #(
    parameter int DEPTH  = 256,
    parameter int BYTES  = 4,
    parameter int RD_LAT = 0,
    localparam int AW    = $clog2(DEPTH),
    localparam int NW    = $clog2(BYTES),
    localparam int WW    = 8 * BYTES
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [AW-1:0] addr,
    input  logic [NW-1:0] nbytes,
    input  logic          big_endian,
    output logic [WW-1:0] word,
    output logic          busy,
    output logic          done,
    input  logic [7:0]    rd_data,
    output logic [AW-1:0] rd_addr,
    output logic          rd_clock
);
    localparam int LW = NW + 1;
    localparam logic [1:0] LAT_M1 = (RD_LAT == 0) ? 2'd0 : 2'(RD_LAT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, WAIT} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic          rd_clock_q, rd_clock_d;
    logic [WW-1:0] word_q, word_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [LW-1:0] k_q, k_d;
    logic [LW-1:0] len_q, len_d;
    logic          be_q, be_d;
    logic [1:0]    wcnt_q, wcnt_d;
    logic          capture;
    logic [LW-1:0] pos;

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        word_d     = word_q;
        busy_d     = busy_q;
        done_d     = done_q;
        k_d        = k_q;
        len_d      = len_q;
        be_d       = be_q;
        wcnt_d     = wcnt_q;
        capture    = 1'b0;
        pos        = be_q ? (len_q - LW'(1) - k_q) : k_q;

        case (state_q)
            SETUP:  state_d = STROBE;
            STROBE: begin
                if (RD_LAT == 0) begin
                    capture = 1'b1;
                end else begin
                    state_d = WAIT;
                    wcnt_d  = 2'd0;
                end
            end
            WAIT: begin
                if (wcnt_q == LAT_M1) capture = 1'b1;
                else                  wcnt_d  = wcnt_q + 2'd1;
            end
            default: ;
        endcase

        if (capture) begin
            for (int i = 0; i < BYTES; i++) begin
                if (pos == LW'(i)) word_d[8*i +: 8] = rd_data;
            end
            rd_addr_d = rd_addr_q + AW'(1);
            k_d       = k_q + LW'(1);
            if (k_q + LW'(1) == len_q) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                state_d = SETUP;
            end
        end

        // A new request overrides whatever the sequencer decided this cycle.
        if (start) begin
            state_d   = SETUP;
            rd_addr_d = addr;
            word_d    = '0;
            busy_d    = 1'b1;
            done_d    = 1'b0;
            k_d       = '0;
            len_d     = (nbytes == '0) ? LW'(BYTES) : {1'b0, nbytes};
            be_d      = big_endian;
            wcnt_d    = 2'd0;
        end

        rd_clock_d = (state_d == STROBE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rd_addr_q  <= '0;
            rd_clock_q <= 1'b0;
            word_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            k_q        <= '0;
            len_q      <= '0;
            be_q       <= 1'b0;
            wcnt_q     <= 2'd0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            rd_clock_q <= rd_clock_d;
            word_q     <= word_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            k_q        <= k_d;
            len_q      <= len_d;
            be_q       <= be_d;
            wcnt_q     <= wcnt_d;
        end
    end

    assign word     = word_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_addr  = rd_addr_q;
    assign rd_clock = rd_clock_q;
endmodule

// File: tb/tb_read_word_gather.sv
// Directed bench for read_word_gather: one zero-latency and one two-cycle-latency instance
// share stimulus; a word scoreboard plus cycle, strobe and address checks.
module tb_read_word_gather;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic        big_endian = 1'b0;
    logic [7:0]  addr = '0;
    logic [1:0]  nbytes = '0;
    logic [31:0] word0, word2;
    logic        busy0, busy2, done0, done2, rd_clock0, rd_clock2;
    logic [7:0]  rd_addr0, rd_addr2, rd_data0, rd_data2;

    logic [7:0]  mem [256];
    logic [31:0] exp_q [$];
    int          vectors = 0;
    int          miscompares = 0;
    int          pulses = 0;
    int          p0;
    logic [7:0]  addr_log [256];
    logic [1:0]  v = '0;
    logic [7:0]  a0, a1;

    always #5 clk = ~clk;

    read_word_gather #(.DEPTH(256), .BYTES(4), .RD_LAT(0)) u0 (
        .clk(clk), .reset_n(reset_n), .start(start), .addr(addr), .nbytes(nbytes),
        .big_endian(big_endian), .word(word0), .busy(busy0), .done(done0),
        .rd_data(rd_data0), .rd_addr(rd_addr0), .rd_clock(rd_clock0));

    read_word_gather #(.DEPTH(256), .BYTES(4), .RD_LAT(2)) u2 (
        .clk(clk), .reset_n(reset_n), .start(start), .addr(addr), .nbytes(nbytes),
        .big_endian(big_endian), .word(word2), .busy(busy2), .done(done2),
        .rd_data(rd_data2), .rd_addr(rd_addr2), .rd_clock(rd_clock2));

    // ROM models: data is valid only in the cycle the engine is supposed to sample it.
    assign rd_data0 = rd_clock0 ? mem[rd_addr0] : 8'h5A;
    assign rd_data2 = v[1] ? mem[a1] : 8'hA5;

    always @(posedge clk) begin
        v  <= {v[0], rd_clock2};
        a0 <= rd_addr2;
        a1 <= a0;
        if (rd_clock0) begin
            addr_log[pulses[7:0]] <= rd_addr0;
            pulses <= pulses + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic run(input logic [7:0] a_i, input logic [1:0] nb, input logic be,
                       input bit lat2, input logic [31:0] exp_w, input int exp_cyc,
                       input string tag);
        int n;
        @(negedge clk);
        start = 1'b1; addr = a_i; nbytes = nb; big_endian = be;
        exp_q.push_back(exp_w);
        p0 = pulses;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(lat2 ? done2 : done0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " cycles"}, 64'(n), 64'(exp_cyc));
        chk({tag, " word"}, 64'(lat2 ? word2 : word0), 64'(exp_q.pop_front()));
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        mem[8'h20] = 8'hAA; mem[8'h21] = 8'hBB; mem[8'h22] = 8'hCC;
        mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33; mem[8'h01] = 8'h44;

        #1 reset_n = 1'b0;
        #2;
        chk("rst word", 64'(word0), 64'h0);
        chk("rst busy", 64'(busy0), 64'h0);
        chk("rst done", 64'(done0), 64'h0);
        chk("rst rd_addr", 64'(rd_addr0), 64'h0);
        chk("rst rd_clock", 64'(rd_clock0), 64'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Little-endian, full width.
        run(8'h10, 2'd0, 1'b0, 1'b0, 32'h13121110, 8, "t1");
        chk("t1 pulses", 64'(pulses - p0), 64'd4);
        chk("t1 rd_addr", 64'(rd_addr0), 64'h14);
        chk("t1 busy", 64'(busy0), 64'h0);

        // Big-endian, three bytes; done is a level and word holds.
        run(8'h20, 2'd3, 1'b1, 1'b0, 32'h00AABBCC, 6, "t2");
        chk("t2 rd_addr", 64'(rd_addr0), 64'h23);
        repeat (3) @(negedge clk);
        chk("t2 done hold", 64'(done0), 64'h1);
        chk("t2 word hold", 64'(word0), 64'h00AABBCC);

        // Address wrap at the top of memory.
        run(8'hFE, 2'd0, 1'b0, 1'b0, 32'h44332211, 8, "t3");
        for (int i = 0; i < 4; i++)
            chk("t3 addr seq", 64'(addr_log[8'(p0 + i)]), 64'(8'(8'hFE + i)));
        chk("t3 rd_addr", 64'(rd_addr0), 64'h02);

        // Two-cycle read latency instance.
        run(8'h30, 2'd2, 1'b0, 1'b1, 32'h00003130, 8, "t4");

        // Restart in the middle of a sequence.
        @(negedge clk);
        start = 1'b1; addr = 8'h10; nbytes = 2'd0; big_endian = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5 first byte", 64'(word0), 64'h10);
        start = 1'b1; addr = 8'h40;
        exp_q.push_back(32'h43424140);
        @(negedge clk);
        start = 1'b0;
        chk("t5 cleared", 64'(word0), 64'h0);
        chk("t5 no done", 64'(done0), 64'h0);
        n = 0;
        while (!done0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t5 cycles", 64'(n), 64'd8);
        chk("t5 word", 64'(word0), 64'(exp_q.pop_front()));

        // Asynchronous reset mid-sequence.
        @(negedge clk);
        start = 1'b1; addr = 8'h50;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6 busy before", 64'(busy0), 64'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6 word", 64'(word0), 64'h0);
        chk("t6 busy", 64'(busy0), 64'h0);
        chk("t6 done", 64'(done0), 64'h0);
        chk("t6 rd_addr", 64'(rd_addr0), 64'h0);
        chk("t6 rd_clock", 64'(rd_clock0), 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        p0 = pulses;
        repeat (4) @(negedge clk);
        chk("t6 idle busy", 64'(busy0), 64'h0);
        chk("t6 idle done", 64'(done0), 64'h0);
        chk("t6 idle word", 64'(word0), 64'h0);
        chk("t6 idle rd_addr", 64'(rd_addr0), 64'h0);
        chk("t6 idle pulses", 64'(pulses - p0), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
